// File: rtl/max_keyboard_pkg.sv
// Shared types, prefix bytes and the PS/2 set-2 to C64 matrix map.
package max_kbd_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] KC_F0 = 8'hF0;
  localparam logic [7:0] KC_E0 = 8'hE0;
  localparam logic [7:0] KC_E1 = 8'hE1;

  // Matrix entry: {hit, col[2:0], row[2:0]}; col is the PA bit, row the PB bit.
  function automatic logic [6:0] km(input int unsigned c, input int unsigned r);
    return {1'b1, 3'(c), 3'(r)};
  endfunction

  // Keyboard acknowledges, self-test results and overrun bytes.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
  endfunction

  // E0 12 / E0 59 (fake shifts) fall through to the miss default.
  function automatic logic [6:0] kbd_lookup(input logic ext, input logic [7:0] b);
    logic [6:0] m;
    m = '0;
    if (ext) begin
      case (b)
        8'h71: m = km(0, 0); 8'h5A: m = km(0, 1);
        8'h74: m = km(0, 2); 8'h72: m = km(0, 7);
        8'h6C: m = km(6, 3); 8'h14: m = km(7, 2);
        8'h11: m = km(7, 5);
        default: m = '0;
      endcase
    end else begin
      case (b)
        8'h66: m = km(0, 0); 8'h5A: m = km(0, 1); 8'h83: m = km(0, 3);
        8'h05: m = km(0, 4); 8'h04: m = km(0, 5); 8'h03: m = km(0, 6);
        8'h26: m = km(1, 0); 8'h1D: m = km(1, 1); 8'h1C: m = km(1, 2);
        8'h25: m = km(1, 3); 8'h1A: m = km(1, 4); 8'h1B: m = km(1, 5);
        8'h24: m = km(1, 6); 8'h12: m = km(1, 7);
        8'h2E: m = km(2, 0); 8'h2D: m = km(2, 1); 8'h23: m = km(2, 2);
        8'h36: m = km(2, 3); 8'h21: m = km(2, 4); 8'h2B: m = km(2, 5);
        8'h2C: m = km(2, 6); 8'h22: m = km(2, 7);
        8'h3D: m = km(3, 0); 8'h35: m = km(3, 1); 8'h34: m = km(3, 2);
        8'h3E: m = km(3, 3); 8'h32: m = km(3, 4); 8'h33: m = km(3, 5);
        8'h3C: m = km(3, 6); 8'h2A: m = km(3, 7);
        8'h46: m = km(4, 0); 8'h43: m = km(4, 1); 8'h3B: m = km(4, 2);
        8'h45: m = km(4, 3); 8'h3A: m = km(4, 4); 8'h42: m = km(4, 5);
        8'h44: m = km(4, 6); 8'h31: m = km(4, 7);
        8'h4E: m = km(5, 0); 8'h4D: m = km(5, 1); 8'h4B: m = km(5, 2);
        8'h55: m = km(5, 3); 8'h49: m = km(5, 4); 8'h4C: m = km(5, 5);
        8'h54: m = km(5, 6); 8'h41: m = km(5, 7);
        8'h5D: m = km(6, 0); 8'h5B: m = km(6, 1); 8'h52: m = km(6, 2);
        8'h59: m = km(6, 4); 8'h4A: m = km(6, 7);
        8'h16: m = km(7, 0); 8'h14: m = km(7, 2); 8'h1E: m = km(7, 3);
        8'h29: m = km(7, 4); 8'h11: m = km(7, 5); 8'h15: m = km(7, 6);
        8'h76: m = km(7, 7);
        default: m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/max_keyboard_if.sv
// CIA port pins plus the receiver status seen by the rest of the core.
interface max_keyboard_if;
  logic [7:0] pao_i;
  logic [7:0] pbo_i;
  logic [7:0] pai_o;
  logic [7:0] pbi_o;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  modport master (output pao_i, pbo_i, input pai_o, pbi_o, code, code_valid, frame_err);
  modport slave  (input pao_i, pbo_i, output pai_o, pbi_o, code, code_valid, frame_err);
endinterface

// File: rtl/max_keyboard_ps2_rx.sv
// PS/2 byte receiver: synchroniser, clock glitch filter, frame FSM, timeout.
module ps2_rx
  import max_kbd_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_code,
  output logic       o_code_valid,
  output logic       o_frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic          r_filt, r_filt_d;
  logic [FW-1:0] r_fcnt;
  logic [TW-1:0] r_tocnt;
  rx_state_t     r_state, w_state;
  logic [7:0]    r_shift, w_shift, r_code, w_code;
  logic [2:0]    r_bitcnt, w_bitcnt;
  logic          r_par_ok, w_par_ok, r_valid, w_valid, r_err, w_err;
  logic          w_fall, w_edge, w_timeout;

  assign w_fall    = r_filt_d & ~r_filt;
  assign w_edge    = r_filt_d ^ r_filt;
  assign w_timeout = (r_state != RX_IDLE) && (r_tocnt == TW'(TIMEOUT_CYCLES));

  // Two-stage synchronisers; idle PS/2 lines are high.
  always_ff @(posedge clk) begin
    if (reset) begin
      {r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync} <= '1;
    end else begin
      r_clk_meta <= i_ps2_clk;  r_clk_sync <= r_clk_meta;
      r_dat_meta <= i_ps2_data; r_dat_sync <= r_dat_meta;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_filt_d <= r_filt;
      if (r_clk_sync != r_filt) begin
        if (r_fcnt == FW'(FILTER_LEN - 1)) begin
          r_filt <= r_clk_sync;
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end else begin
        r_fcnt <= '0;
      end
    end
  end

  // Idle-time counter, cleared by any filtered clock edge or while idle.
  always_ff @(posedge clk) begin
    if (reset || w_edge || (r_state == RX_IDLE)) r_tocnt <= '0;
    else if (!w_timeout)                          r_tocnt <= r_tocnt + 1'b1;
  end

  // Frame FSM state and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= RX_IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par_ok <= 1'b0;
      r_code   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_shift  <= w_shift;
      r_bitcnt <= w_bitcnt;
      r_par_ok <= w_par_ok;
      r_code   <= w_code;
      r_valid  <= w_valid;
      r_err    <= w_err;
    end
  end

  // Next state: one step per filtered falling edge, timeout wins when idle-stalled.
  always_comb begin
    w_state  = r_state;
    w_shift  = r_shift;
    w_bitcnt = r_bitcnt;
    w_par_ok = r_par_ok;
    w_code   = r_code;
    w_valid  = 1'b0;
    w_err    = 1'b0;
    if (w_timeout) begin
      w_state = RX_IDLE;
      w_err   = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        RX_IDLE: if (!r_dat_sync) begin
          w_state  = RX_DATA;
          w_bitcnt = '0;
        end
        RX_DATA: begin
          w_shift  = {r_dat_sync, r_shift[7:1]};
          w_bitcnt = r_bitcnt + 1'b1;
          if (r_bitcnt == 3'd7) w_state = RX_PARITY;
        end
        RX_PARITY: begin
          w_par_ok = ^{r_shift, r_dat_sync};
          w_state  = RX_STOP;
        end
        RX_STOP: begin
          if (r_dat_sync && r_par_ok) begin
            w_valid = 1'b1;
            w_code  = r_shift;
          end else begin
            w_err = 1'b1;
          end
          w_state = RX_IDLE;
        end
        default: w_state = RX_IDLE;
      endcase
    end
  end

  assign o_code       = r_code;
  assign o_code_valid = r_valid;
  assign o_frame_err  = r_err;

endmodule

// File: rtl/max_keyboard.sv
// PS/2 keyboard to C64/MAX 8x8 matrix, scanned through the CIA port pins.
module max_keyboard
  import max_kbd_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ps2_kbd_clk,
  input  logic          ps2_kbd_data,
  max_keyboard_if.slave bus
);

  logic [7:0]      w_code;
  logic            w_code_valid, w_frame_err;
  logic [6:0]      w_lk;
  logic [7:0][7:0] r_key;   // [col][row]
  logic            r_brk, r_ext;
  logic [2:0]      r_skip;
  logic [7:0]      w_pai, w_pbi, r_pai, r_pbi;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .i_ps2_clk   (ps2_kbd_clk),
    .i_ps2_data  (ps2_kbd_data),
    .o_code      (w_code),
    .o_code_valid(w_code_valid),
    .o_frame_err (w_frame_err)
  );

  assign w_lk = kbd_lookup(r_ext, w_code);

  // Prefix tracking and matrix write for each accepted byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key  <= '0;
      r_brk  <= 1'b0;
      r_ext  <= 1'b0;
      r_skip <= '0;
    end else if (w_code_valid) begin
      if (r_skip != 3'd0)         r_skip <= r_skip - 1'b1;
      else if (w_code == KC_E1)   r_skip <= 3'd7;
      else if (w_code == KC_F0)   r_brk  <= 1'b1;
      else if (w_code == KC_E0)   r_ext  <= 1'b1;
      else if (!is_ignored(w_code)) begin
        if (w_lk[6]) r_key[w_lk[5:3]][w_lk[2:0]] <= ~r_brk;
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end
    end
  end

  // Passive matrix: a closed key pulls its row/column low when the other side is driven.
  always_comb begin
    w_pai = '1;
    w_pbi = '1;
    for (int unsigned c = 0; c < 8; c++) begin
      for (int unsigned r = 0; r < 8; r++) begin
        if (r_key[c][r] && !bus.pao_i[c]) w_pbi[r] = 1'b0;
        if (r_key[c][r] && !bus.pbo_i[r]) w_pai[c] = 1'b0;
      end
    end
  end

  // Registered scan outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pai <= '1;
      r_pbi <= '1;
    end else begin
      r_pai <= w_pai;
      r_pbi <= w_pbi;
    end
  end

  assign bus.pai_o      = r_pai;
  assign bus.pbi_o      = r_pbi;
  assign bus.code       = w_code;
  assign bus.code_valid = w_code_valid;
  assign bus.frame_err  = w_frame_err;

endmodule

// File: tb/tb_max_keyboard.sv
// Scoreboard bench for max_keyboard: PS/2 frames in, receiver events and CIA scan out.
module tb_max_keyboard;

  localparam int unsigned TO = 2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2c = 1'b1;
  logic ps2d = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [8:0] sb[$];          // {is_err, code}
  logic [7:0] last_code = 8'h00;

  max_keyboard_if u_if ();

  max_keyboard #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_kbd_clk (ps2c),
    .ps2_kbd_data(ps2d),
    .bus         (u_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every receiver event must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && (u_if.code_valid || u_if.frame_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_evt", 1, 0);
      end else begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("evt_err", u_if.frame_err, e[8]);
        chk("evt_valid", u_if.code_valid, !e[8]);
        if (!e[8]) begin
          chk("evt_code", u_if.code, e[7:0]);
          last_code = e[7:0];
        end else begin
          chk("code_held", u_if.code, last_code);
        end
      end
    end
  end

  task automatic ps2_bits(input logic [10:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk) ps2d = bits[i];
      repeat (10) @(negedge clk);
      ps2c = 1'b0;
      repeat (20) @(negedge clk);
      ps2c = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2d = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input logic bad_par, input logic stop, input logic is_err);
    logic [10:0] bits;
    bits = {stop, (~^b) ^ bad_par, b, 1'b0};
    sb.push_back({is_err, b});
    ps2_bits(bits, 11);
    repeat (5) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic send(input logic [7:0] b);
    frame(b, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drive(input logic [7:0] pa, input logic [7:0] pb);
    @(negedge clk);
    u_if.pao_i = pa;
    u_if.pbo_i = pb;
    @(negedge clk);
  endtask

  initial begin
    u_if.pao_i = 8'hFE;
    u_if.pbo_i = 8'hFF;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_pbi", u_if.pbi_o, 8'hFF);
    chk("rst_pai", u_if.pai_o, 8'hFF);
    chk("rst_code", u_if.code, 8'h00);
    chk("rst_valid", u_if.code_valid, 0);
    chk("rst_err", u_if.frame_err, 0);

    // A press, with one-clock scan latency check
    send(8'h1C);
    @(negedge clk);
    u_if.pao_i = 8'hFD;
    #1 chk("scan_lat_old", u_if.pbi_o, 8'hFF);
    @(negedge clk);
    chk("a_pbi", u_if.pbi_o, 8'hFB);
    send(8'hF0); send(8'h1C);
    chk("a_rel", u_if.pbi_o, 8'hFF);

    // Two keys in one column, then row-drive direction
    send(8'h1C); send(8'h12);
    chk("two_pbi", u_if.pbi_o, 8'h7B);
    drive(8'hFF, 8'h7F);
    chk("two_pai", u_if.pai_o, 8'hFD);
    chk("two_pbi_nodrive", u_if.pbi_o, 8'hFF);
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("two_rel_pai", u_if.pai_o, 8'hFF);

    // Parity and stop errors leave the matrix alone
    drive(8'hFE, 8'hFF);
    frame(8'h5A, 1'b1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("par_pbi", u_if.pbi_o, 8'hFF);
    chk("par_code", u_if.code, 8'h12);
    drive(8'hFD, 8'hFF);
    frame(8'h1C, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("stop_pbi", u_if.pbi_o, 8'hFF);

    // Pause sequence: E1 swallows the next seven bytes
    send(8'hE1);
    for (int i = 0; i < 7; i++) send(8'h1C);
    chk("pause_pbi", u_if.pbi_o, 8'hFF);
    send(8'h1C);
    chk("after_pause_pbi", u_if.pbi_o, 8'hFB);
    send(8'hF0); send(8'h1C);

    // Stall after four data bits until timeout
    sb.push_back({1'b1, 8'h00});
    ps2_bits({1'b1, 1'b1, 8'h29, 1'b0}, 5);
    for (int i = 0; i < TO + 500 && sb.size() != 0; i++) @(negedge clk);
    chk("timeout_evt", sb.size(), 0);
    sb.delete();
    send(8'h29);
    drive(8'h7F, 8'hFF);
    chk("space_pbi", u_if.pbi_o, 8'hEF);

    // Fake shift then real shift
    drive(8'hFD, 8'hFF);
    send(8'hE0); send(8'h12);
    chk("fake_shift", u_if.pbi_o, 8'hFF);
    send(8'h12);
    chk("real_shift", u_if.pbi_o, 8'h7F);

    // Reset with a key held
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("rst_held_pbi", u_if.pbi_o, 8'hFF);
    chk("rst_held_code", u_if.code, 8'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cleared", u_if.pbi_o, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
